// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter for a shared sync_fifo.
// Grants one packet source at a time; bursts are capped at MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2,
   parameter int MAX_BURST  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           fifo_full,
   output logic                           fifo_wr_en,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
   output logic                           grant_valid,
   output logic [ID_WIDTH-1:0]            grant_id,
   output logic                           split_pulse
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   gid_q, gid_d;
   logic [ID_WIDTH-1:0]   last_q, last_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  split_q, split_d;

   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [ID_WIDTH-1:0]   winner;
   logic                  cur_valid;
   logic                  cur_last;
   logic                  xfer;
   logic                  burst_end;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // First valid requester strictly after the previous owner, with wrap.
   function automatic logic [ID_WIDTH-1:0] rr_pick(
      input logic [NUM_REQ-1:0]  v,
      input logic [ID_WIDTH-1:0] last
   );
      logic [ID_WIDTH-1:0] w;
      logic                hit;
      int                  idx;
      w   = '0;
      hit = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!hit && v[ID_WIDTH'(idx)]) begin
            hit = 1'b1;
            w   = ID_WIDTH'(idx);
         end
      end
      return w;
   endfunction

   assign winner    = rr_pick(req_valid, last_q);
   assign cur_valid = req_valid[gid_q];
   assign cur_last  = req_last[gid_q];
   assign xfer      = (state_q == LOCK) && cur_valid && !fifo_full;
   assign burst_end = (cnt_q + CW'(1)) == CW'(MAX_BURST);

   always_comb begin
      req_ready = '0;
      if (state_q == LOCK && !fifo_full) begin
         req_ready[gid_q] = 1'b1;
      end
   end

   assign fifo_wr_en = xfer;
   assign fifo_wdata = xfer ? {gid_q, data_arr[gid_q]} : '0;

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      split_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d = LOCK;
               gid_d   = winner;
               cnt_d   = '0;
            end
         end
         LOCK: begin
            if (xfer) begin
               cnt_d = cnt_q + CW'(1);
               if (cur_last) begin
                  state_d = IDLE;
                  last_d  = gid_q;
               end else if (burst_end) begin
                  state_d = IDLE;
                  last_d  = gid_q;
                  split_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gid_q   <= '0;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         cnt_q   <= '0;
         split_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         split_q <= split_d;
      end
   end

   assign grant_valid = (state_q == LOCK);
   assign grant_id    = gid_q;
   assign split_pulse = split_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter.
// Sources feed per-requester packet queues; a monitor checks every cycle.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 8;
   localparam int IW      = 2;
   localparam int MAXB    = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic                  clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [IW+DW-1:0]      fifo_wdata;
   logic                  grant_valid;
   logic [IW-1:0]         grant_id;
   logic                  split_pulse;

   fifo_wr_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
      .grant_valid(grant_valid), .grant_id(grant_id),
      .split_pulse(split_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   beat_t         src_q [NUM_REQ][$];
   logic [DW-1:0] exp_q [NUM_REQ][$];
   int            wr_cnt [NUM_REQ];
   int            split_cnt = 0;

   bit drv_en = 0, mon_en = 0, do_rst = 0;
   int p_valid = 100, p_full = 0;
   int full_hold = 0, gap_req = 0, gap_cnt = 0;
   logic [NUM_REQ-1:0] acc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
      int c;
      for (int s = 1; s <= NUM_REQ; s++) begin
         c = (last + s) % NUM_REQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NUM_REQ; i++)
         if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 0;
      return 1;
   endfunction

   task automatic push_pkt(input int id, input int len, input int first,
                           input bit rnd);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = rnd ? DW'($urandom) : DW'(first + k);
         b.last = (k == len - 1);
         src_q[id].push_back(b);
         exp_q[id].push_back(b.data);
      end
   endtask

   // Source driver: advance on accepted beats, then present the next head.
   initial begin
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (drv_en) begin
            if (do_rst) begin
               do_rst = 0;
               rst = 1'b1;
               for (int i = 0; i < NUM_REQ; i++) begin
                  src_q[i].delete();
                  exp_q[i].delete();
               end
               req_valid = '0;
               req_last  = '0;
               req_data  = '0;
               fifo_full = 1'b0;
            end else begin
               rst = 1'b0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                  if (gap_cnt > 0 && i == gap_req)
                     req_valid[i] = 1'b0;
                  else
                     req_valid[i] = (src_q[i].size() != 0) &&
                                    ($urandom_range(99) < p_valid);
                  if (src_q[i].size() != 0) begin
                     req_data[i*DW +: DW] = src_q[i][0].data;
                     req_last[i]          = src_q[i][0].last;
                  end else begin
                     req_data[i*DW +: DW] = '0;
                     req_last[i]          = 1'b0;
                  end
               end
               if (gap_cnt > 0) gap_cnt--;
               if (full_hold > 0) begin
                  fifo_full = 1'b1;
                  full_hold--;
               end else begin
                  fifo_full = ($urandom_range(99) < p_full);
               end
            end
         end
      end
   end

   // Reference model: who owns the FIFO, and how many beats it has written.
   int               owner = -1;
   int               beats = 0;
   int               last_g = NUM_REQ - 1;
   bit               e_split = 0;
   logic [NUM_REQ-1:0] e_rdy;
   logic             e_wr;
   logic [IW+DW-1:0] e_wd;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("grant_valid", 32'(grant_valid), 32'(owner >= 0));
         if (owner >= 0) chk("grant_id", 32'(grant_id), owner);
         e_rdy = '0;
         if (owner >= 0 && !fifo_full) e_rdy[owner] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(e_rdy));
         e_wr = (owner >= 0) && req_valid[owner] && !fifo_full;
         chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
         chk("split_pulse", 32'(split_pulse), 32'(e_split));
         if (split_pulse) split_cnt++;
         e_wd = '0;
         if (e_wr) begin
            chk("beat_available", 32'(exp_q[owner].size() != 0), 32'd1);
            if (exp_q[owner].size() != 0)
               e_wd = {IW'(owner), exp_q[owner].pop_front()};
            wr_cnt[owner]++;
         end
         chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
         e_split = 0;
         if (rst) begin
            owner  = -1;
            beats  = 0;
            last_g = NUM_REQ - 1;
         end else if (owner < 0) begin
            if (|req_valid) begin
               owner = rr_pick(last_g, req_valid);
               beats = 0;
            end
         end else if (e_wr) begin
            beats++;
            if (req_last[owner]) begin
               last_g = owner;
               owner  = -1;
            end else if (beats == MAXB) begin
               last_g  = owner;
               owner   = -1;
               e_split = 1;
            end
         end
      end
   end

   task automatic wait_writes(input int id, input int n, input string name);
      int base;
      int k;
      base = wr_cnt[id];
      k = 0;
      while (k < 500 && wr_cnt[id] < base + n) begin
         @(posedge clk);
         k++;
      end
      chk(name, 32'(wr_cnt[id] >= base + n), 32'd1);
   endtask

   task automatic drain(input int budget, input string name);
      int k;
      k = 0;
      while (k < budget && !all_empty()) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      chk(name, 32'(all_empty()), 32'd1);
   endtask

   int b0, b1, b3, s0;

   initial begin
      for (int i = 0; i < NUM_REQ; i++) wr_cnt[i] = 0;
      rst = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1;
      drv_en = 1;
      @(negedge clk);
      chk("reset grant_valid", 32'(grant_valid), 32'd0);
      chk("reset grant_id", 32'(grant_id), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset wr_en", 32'(fifo_wr_en), 32'd0);
      chk("reset wdata", 32'(fifo_wdata), 32'd0);

      // Single requester, three beats.
      @(posedge clk);
      push_pkt(2, 3, 'hA1, 0);
      drain(100, "single_drain");
      chk("single_count", wr_cnt[2], 3);

      // Round-robin among 0, 1 and 3.
      @(posedge clk);
      b0 = wr_cnt[0];
      b1 = wr_cnt[1];
      b3 = wr_cnt[3];
      for (int r = 0; r < 2; r++) begin
         push_pkt(0, 1, 'h10 + r, 0);
         push_pkt(1, 1, 'h20 + r, 0);
         push_pkt(3, 1, 'h30 + r, 0);
      end
      drain(100, "rr_drain");
      chk("rr_counts", (wr_cnt[0]-b0) + (wr_cnt[1]-b1) + (wr_cnt[3]-b3), 6);
      chk("rr_req2_idle", wr_cnt[2], 3);

      // 20-beat packet splits after beats 8 and 16.
      @(posedge clk);
      b1 = wr_cnt[1];
      s0 = split_cnt;
      push_pkt(1, 20, 'h40, 0);
      drain(200, "burst_drain");
      chk("burst_beats", wr_cnt[1] - b1, 20);
      chk("burst_splits", split_cnt - s0, 2);

      // FIFO full for five cycles mid-packet.
      @(posedge clk);
      b1 = wr_cnt[1];
      push_pkt(1, 6, 'h60, 0);
      wait_writes(1, 2, "full_start");
      full_hold = 5;
      drain(200, "full_drain");
      chk("full_beats", wr_cnt[1] - b1, 6);

      // Valid gap while another requester waits.
      @(posedge clk);
      b0 = wr_cnt[0];
      push_pkt(0, 6, 'h70, 0);
      wait_writes(0, 1, "gap_grant");
      b3 = wr_cnt[3];
      push_pkt(3, 1, 'h7F, 0);
      wait_writes(0, 1, "gap_second");
      gap_req = 0;
      gap_cnt = 3;
      wait_writes(0, 4, "gap_rest");
      chk("gap_held", wr_cnt[3] - b3, 0);
      drain(200, "gap_drain");
      chk("gap_served", wr_cnt[3] - b3, 1);

      // Reset after beat 2 of 5, then 0 and 3 compete.
      @(posedge clk);
      push_pkt(2, 5, 'h80, 0);
      wait_writes(2, 2, "rst_start");
      do_rst = 1;
      @(negedge clk);
      @(negedge clk);
      chk("rst grant_valid", 32'(grant_valid), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst grant_id", 32'(grant_id), 32'd0);
      b0 = wr_cnt[0];
      b3 = wr_cnt[3];
      push_pkt(3, 1, 'h93, 0);
      push_pkt(0, 1, 'h90, 0);
      wait_writes(0, 1, "rst_req0");
      chk("rst_req0_first", wr_cnt[3] - b3, 0);
      drain(100, "rst_drain");

      // Random traffic with stalls and backpressure.
      p_valid = 70;
      p_full  = 20;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         push_pkt($urandom_range(NUM_REQ - 1), $urandom_range(1, 12), 0, 1);
         repeat ($urandom_range(0, 6)) @(posedge clk);
      end
      drain(6000, "random_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter sharing one `sync_fifo` between NUM_REQ packet sources. It grants one requester at a time and holds the grant until that requester's packet ends or MAX_BURST beats have been written. It drives the FIFO write port directly, tagging each beat with the source ID. It sits between the producer units and the shared `sync_fifo` instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, payload width per beat
- ID_WIDTH, 2, source-ID width; must equal clog2(NUM_REQ)
- MAX_BURST, 8, maximum beats per grant (≥1); forces re-arbitration

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet, qualified by req_valid
- req_data  in  NUM_REQ*DATA_WIDTH  payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester beat accept
- fifo_full  in  1  full flag from the FIFO
- fifo_wr_en  out  1  FIFO write enable
- fifo_wdata  out  ID_WIDTH+DATA_WIDTH  {grant_id, payload}
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  ID_WIDTH  index of the granted requester
- split_pulse  out  1  one-cycle pulse when a grant is released by MAX_BURST rather than by last

## Operation
- FSM states: IDLE and LOCK.
- **IDLE**
  - grant_valid=0 and all req_ready=0.
  - If any req_valid is set, select the winner by searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the winner into grant_id, clear beat_cnt and go to LOCK.
  - If no req_valid is set, stay in IDLE.
- **LOCK**
  - grant_valid=1.
  - req_ready[grant_id] = ~fifo_full; all other req_ready=0.
  - A beat transfers when req_valid[grant_id] && req_ready[grant_id].
  - On a transfer: fifo_wr_en=1, fifo_wdata={grant_id, req_data[grant_id]}, beat_cnt+1.
- **Release from LOCK** (at the end of a transfer cycle):
  - If the transfer has req_last[grant_id]=1, go to IDLE and set last_grant=grant_id.
  - Otherwise, if beat_cnt+1 == MAX_BURST, go to IDLE, set last_grant=grant_id and pulse split_pulse. The remainder of that packet re-arbitrates like any other request.
- **Stalls in LOCK**
  - req_valid[grant_id] deasserted: hold the grant indefinitely, with no cycle timeout.
  - fifo_full asserted: hold the grant and gate both req_ready and fifo_wr_en.
- fifo_wr_en must never assert while fifo_full=1; the FIFO RAM port writes on wr_en without checking full.
- beat_cnt width is clog2(MAX_BURST)+1 and never wraps.
- Other requesters' valid/last/data inputs are ignored while in LOCK.

## Timing
- **Reset values:**
  - state=IDLE
  - grant_valid=0, grant_id=0
  - last_grant=NUM_REQ-1, so requester 0 wins first
  - beat_cnt=0
  - req_ready=0, fifo_wr_en=0, split_pulse=0
  - fifo_wdata=0 whenever fifo_wr_en=0
- **Arbitration latency:** request seen in cycle T (IDLE) → grant registered at edge T+1 → first possible transfer in cycle T+1. There is one bubble cycle per grant.
- **Throughput:** one beat per cycle while in LOCK with valid=1 and full=0.
- **Output timing:**
  - req_ready and fifo_wr_en are combinational from state, grant_id, req_valid and fifo_full.
  - grant_valid, grant_id and split_pulse are registered.
  - split_pulse is high during the first IDLE cycle after a forced release.
- **Back-to-back packets:** the last beat in cycle T gives IDLE in T+1 and the next grant in T+2. The same requester can win again only if no other requester is valid in the IDLE cycle.
- **Packet edge cases:**
  - A single-beat packet (valid and last in the first LOCK cycle) releases after one beat.
  - MAX_BURST=1 releases after every beat. split_pulse fires unless last=1.
  - last=1 on the MAX_BURST-th beat counts as a normal release, with no split_pulse.
- **Reset mid-packet:** the grant is abandoned and the next cycle is IDLE with reset values. Beats already written stay in the FIFO.

## Test plan
- **Reset, then a single requester.** Req 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last). Expect one IDLE bubble, then fifo_wdata = 0x2A1, 0x2A2, 0x2A3 on consecutive cycles, then grant_valid=0.
- **Round-robin fairness.** Reqs 0, 1 and 3 continuously send 1-beat packets. Expect the grant order 0, 1, 3, 0, 1, 3 with one bubble between grants. Req 2 is never granted.
- **Burst limit.** MAX_BURST=8 and req 1 sends a 20-beat packet while req 0 is idle. Expect splits after beats 8 and 16, with split_pulse at each. The last 4 beats transfer with no split_pulse.
- **FIFO full backpressure.** fifo_full is asserted for 5 cycles mid-packet. Expect req_ready=0 and fifo_wr_en=0 for exactly those cycles, with no beat lost or duplicated and grant_id unchanged.
- **Valid gap.** The granted requester drops valid for 3 cycles while another requester is pending. Expect the grant to be held and the other requester to stay unserved until last.
- **Reset mid-packet.** Assert rst after beat 2 of 5. Expect the next cycle to show grant_valid=0, req_ready=0 and last_grant=NUM_REQ-1, with requester 0 prioritised on re-request.
